hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller: generates the stall (bubble) input for the ID/EX register and the hold and flush controls for the PC and IF/ID. It keeps a shadow copy of the destination and control bits in flight in EX and MEM, so it needs nothing back from the pipeline registers. It covers three cases:
- load-use hazards;
- ID-stage branch/jr operand hazards;
- a busy interval for the multi-cycle HI/LO unit.

## Interface
Parameters:
- MD_LATENCY, 4, busy cycles of the multiply/divide unit after an accepted start (1..15)
- PERF_W, 32, width of the stall-cycle counter

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- id_valid  input  1  ID holds a real instruction
- id_rs, id_rt  input  5  source register numbers in ID
- id_use_rs, id_use_rt  input  1  instruction reads rs / rt
- id_is_branch  input  1  beq/bne/jr: operands compared/used in ID
- id_branch_taken  input  1  ID resolved a taken branch or jump (incl. j/jal/jr)
- id_write_register  input  5  destination register of ID instruction
- id_regwrite, id_memread  input  1  ID instruction writes a register / is a load
- id_md_start  input  1  ID instruction starts mult/div
- id_md_read  input  1  ID instruction reads HI/LO (mfhi/mflo)
- stall  output  1  to ID/EX stall input; insert a bubble
- pc_hold, ifid_hold  output  1  freeze PC and IF/ID
- ifid_flush  output  1  squash the instruction in IF/ID on the next edge
- md_busy  output  1  multi-cycle unit busy
- stall_cycles  output  PERF_W  saturating count of stalled cycles

## Operation
Shadow slots, each holding {rd, regwrite, memread}, are named ex_s and mem_s.
- Each edge: mem_s <= ex_s.
- ex_s <= 0 if stall or !id_valid; otherwise ex_s <= {id_write_register, id_regwrite, id_memread}.

match(s) = s.regwrite && s.rd != 0 && ((id_use_rs && s.rd == id_rs) || (id_use_rt && s.rd == id_rt)).

The hazard terms are combinational and apply only when id_valid:
- load_use = ex_s.memread && match(ex_s)
- br_ex = id_is_branch && match(ex_s)
- br_mem = id_is_branch && mem_s.memread && match(mem_s)
- md_haz = md_cnt != 0 && (id_md_read || id_md_start)

Derived outputs:
- stall = pc_hold = ifid_hold = load_use | br_ex | br_mem | md_haz.
- ifid_flush = id_valid && id_branch_taken && !stall. No flush while stalled; the branch re-evaluates when the stall releases.
- md_busy = (md_cnt != 0).

md_cnt is 4 bits:
- Loads MD_LATENCY when id_valid && id_md_start && !stall.
- Otherwise decrements when non-zero.

stall_cycles increments each cycle stall = 1 and saturates at all-ones.

Reset, when sampled high:
- ex_s, mem_s, md_cnt and stall_cycles clear to 0.
- While reset is high, stall, pc_hold, ifid_hold, ifid_flush and md_busy are forced to 0.

Register 0 never causes a hazard.

## Timing
- Load followed immediately by a dependent instruction: exactly 1 stall cycle. The load moves to MEM, and ex_s becomes a bubble.
- Branch after a dependent ALU producer: 1 stall cycle.
- Branch after a dependent load: 2 stall cycles, via br_ex then br_mem.
- Branch two instructions after a load: 1 cycle (br_mem).
- md_start accepted at edge t: md_busy is high for cycles t+1 .. t+MD_LATENCY.
  - mfhi/mflo or a second start in that window stalls until md_cnt = 0, then proceeds in the same cycle.
- md_start present but stalled by another hazard: counter not loaded; the start is retried.
- Simultaneous hazards: stall is the OR of all terms; there is no priority and no extra cycles.
- Reset mid-stall or mid-busy: next cycle all outputs are 0 and the shadow slots are empty.

## Test plan
- lw $8 then add $9,$8,$8 (use_rs=use_rt=1) -> stall=1 for exactly 1 cycle, stall_cycles=1.
- add $8 then beq $8,$0 (is_branch) -> 1 stall cycle; lw $8 then beq $8 -> 2 stall cycles; lw $0 then beq $0 -> 0 stall cycles.
- mult with MD_LATENCY=4, then mfhi next -> md_busy high 4 cycles, stall high 4 cycles, mfhi proceeds on the 5th cycle.
- Taken branch with no hazard -> ifid_flush=1 for 1 cycle. Taken branch coinciding with load-use -> ifid_flush=0 during the stall and 1 on the release cycle.
- Reset asserted during md busy with md_cnt=3 -> next cycle md_busy=0, stall=0, stall_cycles=0. A following mfhi causes no stall.
- PERF_W=3 with 9 consecutive stall cycles -> stall_cycles saturates at 7.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the ID stage (master) and the hazard controller (slave):
// decoded ID-stage fields in, stall/hold/flush/busy controls and stall counter out.
interface hazard_ctrl_if #(
    parameter int PERF_W = 32
);
    logic              id_valid;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_is_branch;
    logic              id_branch_taken;
    logic [4:0]        id_write_register;
    logic              id_regwrite;
    logic              id_memread;
    logic              id_md_start;
    logic              id_md_read;
    logic              stall;
    logic              pc_hold;
    logic              ifid_hold;
    logic              ifid_flush;
    logic              md_busy;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch,
               id_branch_taken, id_write_register, id_regwrite, id_memread,
               id_md_start, id_md_read,
        input  stall, pc_hold, ifid_hold, ifid_flush, md_busy, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch,
               id_branch_taken, id_write_register, id_regwrite, id_memread,
               id_md_start, id_md_read,
        output stall, pc_hold, ifid_hold, ifid_flush, md_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadows EX/MEM destinations to detect load-use,
// ID-branch operand and HI/LO busy hazards, and drives stall/hold/flush controls.
module hazard_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int PERF_W     = 32
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave hif
);
    typedef struct packed {
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } slot_t;

    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY);

    slot_t             ex_s;
    slot_t             mem_s;
    logic [3:0]        md_cnt;
    logic [PERF_W-1:0] stall_cnt;

    logic load_use;
    logic br_ex;
    logic br_mem;
    logic md_haz;
    logic hazard;
    logic stall_int;

    function automatic logic match_slot(
        input slot_t      s,
        input logic       use_rs,
        input logic       use_rt,
        input logic [4:0] rs,
        input logic [4:0] rt
    );
        return s.regwrite && (s.rd != 5'd0) &&
               ((use_rs && (s.rd == rs)) || (use_rt && (s.rd == rt)));
    endfunction

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic ex_match;
    logic mem_match;

    always_comb begin
        ex_match  = match_slot(ex_s,  hif.id_use_rs, hif.id_use_rt, hif.id_rs, hif.id_rt);
        mem_match = match_slot(mem_s, hif.id_use_rs, hif.id_use_rt, hif.id_rs, hif.id_rt);
        load_use  = ex_s.memread && ex_match;
        br_ex     = hif.id_is_branch && ex_match;
        br_mem    = hif.id_is_branch && mem_s.memread && mem_match;
        md_haz    = (md_cnt != 4'd0) && (hif.id_md_read || hif.id_md_start);
        hazard    = hif.id_valid && (load_use || br_ex || br_mem || md_haz);
        // Controls are held low for the whole reset cycle, not just after it.
        stall_int = !reset && hazard;
    end

    assign hif.stall        = stall_int;
    assign hif.pc_hold      = stall_int;
    assign hif.ifid_hold    = stall_int;
    assign hif.ifid_flush   = !reset && hif.id_valid && hif.id_branch_taken && !stall_int;
    assign hif.md_busy      = !reset && (md_cnt != 4'd0);
    assign hif.stall_cycles = stall_cnt;

    // Shadow EX/MEM slots, HI/LO busy countdown and stall counter
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_s      <= '0;
            mem_s     <= '0;
            md_cnt    <= 4'd0;
            stall_cnt <= '0;
        end else begin
            mem_s <= ex_s;
            if (stall_int || !hif.id_valid) begin
                ex_s <= '0;
            end else begin
                ex_s <= '{rd: hif.id_write_register,
                          regwrite: hif.id_regwrite,
                          memread: hif.id_memread};
            end

            // A start blocked by another hazard is retried, so it must not load.
            if (hif.id_valid && hif.id_md_start && !stall_int) begin
                md_cnt <= MD_LOAD;
            end else if (md_cnt != 4'd0) begin
                md_cnt <= md_cnt - 4'd1;
            end

            if (stall_int) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle comparison against an instruction-history
// model plus hand-counted stall/flush/busy expectations for each scenario.
module tb_hazard_ctrl;
    localparam int MD_LAT  = 4;
    localparam int PW      = 3;
    localparam int SAT_MAX = (1 << PW) - 1;

    logic clk = 1'b0;
    logic reset;

    hazard_ctrl_if #(.PERF_W(PW)) hif ();

    hazard_ctrl #(.MD_LATENCY(MD_LAT), .PERF_W(PW)) dut (
        .clk  (clk),
        .reset(reset),
        .hif  (hif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- model: history of what entered EX each cycle ----------------
    typedef struct packed {
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } ins_t;

    ins_t hist[$];
    int   cyc     = 0;
    int   md_t    = -100;
    int   perf    = 0;
    bit   started = 0;

    function automatic bit depends_on(input ins_t p);
        return p.rw && (p.rd != 5'd0) &&
               ((hif.id_use_rs && p.rd == hif.id_rs) || (hif.id_use_rt && p.rd == hif.id_rt));
    endfunction

    function automatic bit m_busy();
        return !reset && (cyc - md_t >= 1) && (cyc - md_t <= MD_LAT);
    endfunction

    function automatic bit m_stall();
        ins_t prev1;
        ins_t prev2;
        bit   hz;
        prev1 = '0;
        prev2 = '0;
        if (hist.size() >= 1) prev1 = hist[$];
        if (hist.size() >= 2) prev2 = hist[$-1];
        if (reset || !hif.id_valid) return 1'b0;
        hz = (prev1.mr && depends_on(prev1)) ||
             (hif.id_is_branch && depends_on(prev1)) ||
             (hif.id_is_branch && prev2.mr && depends_on(prev2)) ||
             (((cyc - md_t >= 1) && (cyc - md_t <= MD_LAT)) && (hif.id_md_read || hif.id_md_start));
        return hz;
    endfunction

    always @(posedge clk) begin
        bit s;
        if (reset) begin
            hist.delete();
            md_t    = -100;
            perf    = 0;
            started = 1;
        end else begin
            s = m_stall();
            if (s) perf = (perf == SAT_MAX) ? SAT_MAX : perf + 1;
            if (hif.id_valid && hif.id_md_start && !s) md_t = cyc;
            if (s || !hif.id_valid) hist.push_back('0);
            else hist.push_back('{rd: hif.id_write_register, rw: hif.id_regwrite, mr: hif.id_memread});
            if (hist.size() > 2) void'(hist.pop_front());
        end
        cyc++;
    end

    // Per-cycle compare
    always @(negedge clk) begin
        bit es;
        if (started) begin
            es = m_stall();
            chk("stall",        32'(hif.stall),        32'(es));
            chk("pc_hold",      32'(hif.pc_hold),      32'(es));
            chk("ifid_hold",    32'(hif.ifid_hold),    32'(es));
            chk("ifid_flush",   32'(hif.ifid_flush),
                32'(!reset && hif.id_valid && hif.id_branch_taken && !es));
            chk("md_busy",      32'(hif.md_busy),      32'(m_busy()));
            chk("stall_cycles", 32'(hif.stall_cycles), 32'(perf));
        end
    end

    // ---------------- directed stimulus ----------------
    int stalls, flushes, flush_in_stall, busy_cyc;

    task automatic clear_inputs();
        hif.id_valid          = 1'b0;
        hif.id_rs             = 5'd0;
        hif.id_rt             = 5'd0;
        hif.id_use_rs         = 1'b0;
        hif.id_use_rt         = 1'b0;
        hif.id_is_branch      = 1'b0;
        hif.id_branch_taken   = 1'b0;
        hif.id_write_register = 5'd0;
        hif.id_regwrite       = 1'b0;
        hif.id_memread        = 1'b0;
        hif.id_md_start       = 1'b0;
        hif.id_md_read        = 1'b0;
    endtask

    task automatic set_instr(input logic [4:0] rd, input logic rw, input logic mr,
                             input logic [4:0] rs, input logic [4:0] rt,
                             input logic urs, input logic urt, input logic br,
                             input logic tk, input logic ms, input logic mrd);
        hif.id_valid          = 1'b1;
        hif.id_write_register = rd;
        hif.id_regwrite       = rw;
        hif.id_memread        = mr;
        hif.id_rs             = rs;
        hif.id_rt             = rt;
        hif.id_use_rs         = urs;
        hif.id_use_rt         = urt;
        hif.id_is_branch      = br;
        hif.id_branch_taken   = tk;
        hif.id_md_start       = ms;
        hif.id_md_read        = mrd;
    endtask

    // Present an instruction and hold it in ID until the controller releases it.
    task automatic instr(input logic [4:0] rd, input logic rw, input logic mr,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic br,
                         input logic tk, input logic ms, input logic mrd);
        int guard;
        bit st;
        guard = 0;
        set_instr(rd, rw, mr, rs, rt, urs, urt, br, tk, ms, mrd);
        forever begin
            @(negedge clk);
            st = hif.stall;
            if (st) stalls++;
            if (hif.ifid_flush) flushes++;
            if (st && hif.ifid_flush) flush_in_stall++;
            if (hif.md_busy) busy_cyc++;
            @(posedge clk);
            #1;
            if (!st) break;
            guard++;
            if (guard > 30) begin
                errors++;
                $display("FAIL release_timeout at %0t: stalled %0d cycles expected release", $time, guard);
                break;
            end
        end
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        stalls = 0; flushes = 0; flush_in_stall = 0; busy_cyc = 0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        do_reset();

        settle();
        chk("rst_stall",        32'(hif.stall),        32'd0);
        chk("rst_md_busy",      32'(hif.md_busy),      32'd0);
        chk("rst_flush",        32'(hif.ifid_flush),   32'd0);
        chk("rst_stall_cycles", 32'(hif.stall_cycles), 32'd0);
        next_cycle();

        // lw $8 ; add $9,$8,$8
        do_reset();
        instr(5'd8, 1, 1, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
        instr(5'd9, 1, 0, 5'd8, 5'd8, 1, 1, 0, 0, 0, 0);
        settle();
        chk("loaduse_stalls", 32'(stalls), 32'd1);
        chk("loaduse_count",  32'(hif.stall_cycles), 32'd1);

        // add $8 ; beq $8,$0
        do_reset();
        instr(5'd8, 1, 0, 5'd1, 5'd2, 1, 1, 0, 0, 0, 0);
        instr(5'd0, 0, 0, 5'd8, 5'd0, 1, 1, 1, 0, 0, 0);
        chk("alu_branch_stalls", 32'(stalls), 32'd1);

        // lw $8 ; beq $8,$0
        do_reset();
        instr(5'd8, 1, 1, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
        instr(5'd0, 0, 0, 5'd8, 5'd0, 1, 1, 1, 0, 0, 0);
        settle();
        chk("lw_branch_stalls", 32'(stalls), 32'd2);
        chk("lw_branch_count",  32'(hif.stall_cycles), 32'd2);

        // lw $0 ; beq $0,$0
        do_reset();
        instr(5'd0, 1, 1, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
        instr(5'd0, 0, 0, 5'd0, 5'd0, 1, 1, 1, 0, 0, 0);
        chk("r0_branch_stalls", 32'(stalls), 32'd0);

        // lw $8 ; nop ; beq $8
        do_reset();
        instr(5'd8, 1, 1, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
        instr(5'd0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
        instr(5'd0, 0, 0, 5'd8, 5'd0, 1, 1, 1, 0, 0, 0);
        chk("lw_gap_branch_stalls", 32'(stalls), 32'd1);

        // mult ; mfhi
        do_reset();
        instr(5'd0, 0, 0, 5'd4, 5'd5, 1, 1, 0, 0, 1, 0);
        instr(5'd9, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1);
        settle();
        chk("md_stalls",   32'(stalls),   32'd4);
        chk("md_busy_cyc", 32'(busy_cyc), 32'd4);
        chk("md_busy_after", 32'(hif.md_busy), 32'd0);

        // taken jump without hazard
        do_reset();
        instr(5'd0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
        chk("jump_flushes", 32'(flushes), 32'd1);
        chk("jump_stalls",  32'(stalls),  32'd0);

        // lw $8 ; taken jump reading $8
        do_reset();
        instr(5'd8, 1, 1, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
        instr(5'd0, 0, 0, 5'd8, 5'd0, 1, 0, 0, 1, 0, 0);
        chk("flush_lu_stalls",   32'(stalls),         32'd1);
        chk("flush_lu_flushes",  32'(flushes),        32'd1);
        chk("flush_lu_in_stall", 32'(flush_in_stall), 32'd0);

        // reset while md_cnt = 3
        do_reset();
        instr(5'd0, 0, 0, 5'd4, 5'd5, 1, 1, 0, 0, 1, 0);
        set_instr(5'd9, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1);
        settle();
        chk("pre_rst_stall", 32'(hif.stall), 32'd1);
        next_cycle();
        reset = 1'b1;
        settle();
        chk("in_rst_stall",   32'(hif.stall),        32'd0);
        chk("in_rst_md_busy", 32'(hif.md_busy),      32'd0);
        chk("in_rst_count",   32'(hif.stall_cycles), 32'd1);
        next_cycle();
        reset = 1'b0;
        settle();
        chk("post_rst_md_busy", 32'(hif.md_busy),      32'd0);
        chk("post_rst_stall",   32'(hif.stall),        32'd0);
        chk("post_rst_count",   32'(hif.stall_cycles), 32'd0);
        next_cycle();
        stalls = 0;
        instr(5'd9, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1);
        chk("post_rst_mfhi_stalls", 32'(stalls), 32'd0);

        // 9 stall cycles into a 3-bit counter
        do_reset();
        instr(5'd0, 0, 0, 5'd4, 5'd5, 1, 1, 0, 0, 1, 0);
        instr(5'd9, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1);
        instr(5'd0, 0, 0, 5'd4, 5'd5, 1, 1, 0, 0, 1, 0);
        instr(5'd9, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1);
        instr(5'd8, 1, 1, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
        instr(5'd9, 1, 0, 5'd8, 5'd8, 1, 1, 0, 0, 0, 0);
        settle();
        chk("sat_stalls", 32'(stalls),            32'd9);
        chk("sat_count",  32'(hif.stall_cycles),  32'd7);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
